// File: rtl/eth_tx_framer.sv
// RMII transmit framer: preamble/SFD, prefetched payload, zero pad, CRC-32 FCS
// and inter-frame gap, one dibit per clock.
//
// state | meaning
// IDLE  | waiting for start
// PRE   | preamble bytes 0x55
// SFD   | start-frame delimiter 0xD5; first payload byte requested here
// DATA  | payload bytes taken from the hold register
// PAD   | zero bytes up to MIN_PAYLOAD
// FCS   | inverted CRC, low byte first
// IFG   | txen low for the inter-frame gap; done on its last cycle
module eth_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD    = 46,
    parameter int IFG_BYTES      = 12,
    parameter int LEN_WIDTH      = 11
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 readclk,
    input  logic                 inclk,
    input  logic [7:0]           in,
    output logic                 txen,
    output logic [1:0]           txd,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    localparam logic [31:0]          CRC_POLY = 32'hEDB88320;
    localparam logic [LEN_WIDTH-1:0] PRE_LAST = LEN_WIDTH'(PREAMBLE_BYTES - 1);
    localparam logic [LEN_WIDTH-1:0] MIN_L    = LEN_WIDTH'(MIN_PAYLOAD);
    localparam logic [LEN_WIDTH-1:0] IFG_LAST = LEN_WIDTH'(IFG_BYTES * 4 - 1);
    // Underflow enters IFG one cycle early: the err cycle sits ahead of a full gap.
    localparam logic [LEN_WIDTH-1:0] IFG_ERR  = LEN_WIDTH'(IFG_BYTES * 4);

    state_t               state, state_n;
    logic [1:0]           cnt, cnt_n;
    logic [LEN_WIDTH-1:0] tmr, tmr_n;
    logic [LEN_WIDTH-1:0] len_q, len_q_n;
    logic [7:0]           cur, cur_n;
    logic [7:0]           hold, hold_n;
    logic                 hold_vld, hold_vld_n;
    logic                 req, req_n;
    logic [31:0]          crc, crc_n, crc_inv;
    logic                 txen_n, readclk_n, busy_n, done_n, err_n;
    logic [1:0]           txd_n;
    logic                 accept, avail, load_data, end_data;
    logic [7:0]           byte_in;
    logic [1:0]           fcs_idx;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        accept     = inclk & req;
        avail      = hold_vld | accept;
        byte_in    = hold_vld ? hold : in;
        crc_inv    = ~crc;
        state_n    = state;
        cnt_n      = cnt + 2'd1;
        tmr_n      = tmr;
        len_q_n    = len_q;
        cur_n      = cur;
        hold_n     = accept ? in : hold;
        hold_vld_n = hold_vld | accept;
        req_n      = req & ~accept;
        crc_n      = crc;
        readclk_n  = 1'b0;
        err_n      = 1'b0;
        load_data  = 1'b0;
        end_data   = 1'b0;
        fcs_idx    = 2'd0;

        case (state)
            IDLE: begin
                cnt_n = 2'd0;
                if (start) begin
                    state_n    = PRE;
                    tmr_n      = PRE_LAST;
                    len_q_n    = len;
                    cur_n      = 8'h55;
                    crc_n      = '1;
                    hold_vld_n = 1'b0;
                    req_n      = 1'b0;
                end
            end
            PRE: begin
                if (cnt == 2'd3) begin
                    if (tmr == '0) begin
                        state_n   = SFD;
                        cur_n     = 8'hD5;
                        readclk_n = (len_q != '0);
                    end else begin
                        tmr_n = tmr - 1'b1;
                    end
                end
            end
            SFD: begin
                if (cnt == 2'd3) begin
                    if (len_q != '0) begin
                        load_data = 1'b1;
                        tmr_n     = len_q - 1'b1;
                    end else begin
                        end_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt == 2'd3) begin
                    if (tmr != '0) begin
                        load_data = 1'b1;
                        tmr_n     = tmr - 1'b1;
                    end else begin
                        end_data = 1'b1;
                    end
                end
            end
            PAD: begin
                if (cnt == 2'd3) begin
                    if (tmr == '0) begin
                        state_n = FCS;
                        tmr_n   = LEN_WIDTH'(3);
                    end else begin
                        tmr_n = tmr - 1'b1;
                    end
                end
            end
            FCS: begin
                if (cnt == 2'd3) begin
                    if (tmr == '0) begin
                        state_n = IFG;
                        tmr_n   = IFG_LAST;
                    end else begin
                        tmr_n = tmr - 1'b1;
                    end
                end
            end
            IFG: begin
                cnt_n = 2'd0;
                if (tmr == '0) begin
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (end_data) begin
            if (len_q < MIN_L) begin
                state_n = PAD;
                tmr_n   = MIN_L - len_q - 1'b1;
                cur_n   = 8'h00;
            end else begin
                state_n = FCS;
                tmr_n   = LEN_WIDTH'(3);
            end
        end

        // A byte arriving on the very edge it is needed is still usable.
        if (load_data) begin
            hold_vld_n = 1'b0;
            if (avail) begin
                state_n   = DATA;
                cur_n     = byte_in;
                readclk_n = (tmr_n != '0);
            end else begin
                state_n = IFG;
                tmr_n   = IFG_ERR;
                err_n   = 1'b1;
                req_n   = 1'b0;
            end
        end

        if (state_n == FCS) begin
            fcs_idx = 2'd3 - tmr_n[1:0];
            cur_n   = crc_inv[{fcs_idx, 3'b000} +: 8];
        end

        req_n  = req_n | readclk_n;
        txen_n = state_n inside {PRE, SFD, DATA, PAD, FCS};
        txd_n  = txen_n ? cur_n[{cnt_n, 1'b0} +: 2] : 2'b00;
        busy_n = (state_n != IDLE);
        done_n = (state_n == IFG) && (tmr_n == '0);
        if (state_n inside {DATA, PAD}) begin
            crc_n = crc_dibit(crc, txd_n);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            tmr      <= '0;
            len_q    <= '0;
            cur      <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            req      <= 1'b0;
            crc      <= '1;
            txen     <= 1'b0;
            txd      <= 2'b00;
            readclk  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tmr      <= tmr_n;
            len_q    <= len_q_n;
            cur      <= cur_n;
            hold     <= hold_n;
            hold_vld <= hold_vld_n;
            req      <= req_n;
            crc      <= crc_n;
            txen     <= txen_n;
            txd      <= txd_n;
            readclk  <= readclk_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

endmodule
